// File: rtl/dot_acc_pkg.sv
// dot_acc_pkg: shared constants, FSM states and overflow helper for the dot-product accumulator
package dot_acc_pkg;

  localparam int NUM_PROD = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

  // Signed add overflow: operands agree in sign but the result does not
  function automatic logic add_ovf(input logic a_sign, input logic b_sign, input logic s_sign);
    return (a_sign == b_sign) && (s_sign != a_sign);
  endfunction

endpackage

// File: rtl/dot_acc_unit_tree.sv
// prod_adder_tree: combinational 12-input signed adder tree with sign extension to the accumulator width
module prod_adder_tree
  import dot_acc_pkg::*;
#(
  parameter int PROD_SIZE = 18,
  parameter int ACC_SIZE  = 32
) (
  input  logic signed [PROD_SIZE-1:0] i_prod [0:NUM_PROD-1],
  output logic signed [ACC_SIZE-1:0]  o_sum
);

  logic signed [ACC_SIZE-1:0] w_ext [0:NUM_PROD-1];
  logic signed [ACC_SIZE-1:0] w_l1  [0:5];
  logic signed [ACC_SIZE-1:0] w_l2  [0:2];

  for (genvar i = 0; i < NUM_PROD; i++) begin : g_ext
    assign w_ext[i] = {{(ACC_SIZE-PROD_SIZE){i_prod[i][PROD_SIZE-1]}}, i_prod[i]};
  end

  for (genvar i = 0; i < 6; i++) begin : g_l1
    assign w_l1[i] = w_ext[2*i] + w_ext[2*i+1];
  end

  for (genvar i = 0; i < 3; i++) begin : g_l2
    assign w_l2[i] = w_l1[2*i] + w_l1[2*i+1];
  end

  assign o_sum = w_l2[0] + w_l2[1] + w_l2[2];

endmodule

// File: rtl/dot_acc_unit.sv
// dot_acc_unit: reduces 12 partial products per beat, subtracts a correction and accumulates over a job
module dot_acc_unit
  import dot_acc_pkg::*;
#(
  parameter int IN_SIZE_1 = 8,
  parameter int PROD_SIZE = (IN_SIZE_1 + 1) * 2,
  parameter int ACC_SIZE  = 32,
  parameter int CNT_SIZE  = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [CNT_SIZE-1:0]         len_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic signed [PROD_SIZE-1:0] prod_i [0:NUM_PROD-1],
  input  logic signed [ACC_SIZE-1:0]  corr_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic signed [ACC_SIZE-1:0]  out_data_o,
  output logic                        busy_o,
  output logic                        overflow_o
);

  state_e                     r_state, w_next;
  logic [CNT_SIZE-1:0]        r_cnt;
  logic signed [ACC_SIZE-1:0] r_s1, r_acc, w_tree, w_beat, w_sum;
  logic                       r_s1_vld, r_ovf, w_take, w_start;

  prod_adder_tree #(.PROD_SIZE(PROD_SIZE), .ACC_SIZE(ACC_SIZE)) u_tree (
    .i_prod (prod_i),
    .o_sum  (w_tree)
  );

  assign w_beat      = w_tree - corr_i;
  assign w_sum       = r_acc + r_s1;
  assign in_ready_o  = r_state == ACCUM;
  assign out_valid_o = r_state == OUT;
  assign busy_o      = r_state != IDLE;
  assign out_data_o  = r_acc;
  assign overflow_o  = r_ovf;
  assign w_take      = in_valid_i & in_ready_o;
  assign w_start     = (r_state == IDLE) & start_i;

  // Next state: zero-length jobs skip straight to OUT, the last beat passes through DRAIN
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start_i ? ((len_i == '0) ? OUT : ACCUM) : IDLE;
      ACCUM:   w_next = (w_take && r_cnt == CNT_SIZE'(1)) ? DRAIN : ACCUM;
      DRAIN:   w_next = OUT;
      default: w_next = out_ready_i ? IDLE : OUT;
    endcase
  end

  // State register and remaining-beat counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) r_cnt <= len_i;
      else if (w_take) r_cnt <= r_cnt - CNT_SIZE'(1);
    end
  end

  // Stage 1: register the corrected beat sum on every accepted beat
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1     <= '0;
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_vld <= w_take;
      if (w_take) r_s1 <= w_beat;
    end
  end

  // Stage 2: accumulate with a sticky overflow flag, both cleared by an accepted start
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_start) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (r_s1_vld) begin
      r_acc <= w_sum;
      r_ovf <= r_ovf | add_ovf(r_acc[ACC_SIZE-1], r_s1[ACC_SIZE-1], w_sum[ACC_SIZE-1]);
    end
  end

endmodule

// File: tb/tb_dot_acc_unit.sv
// tb_dot_acc_unit: directed and randomized jobs checked against an arithmetic reference model
module tb_dot_acc_unit;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic               start_i = 1'b0;
  logic [7:0]         len_i = '0;
  logic               in_valid_i = 1'b0;
  logic               in_ready_o;
  logic signed [17:0] prod [0:11];
  logic signed [31:0] corr = '0;
  logic               out_valid_o;
  logic               out_ready_i = 1'b0;
  logic signed [31:0] out_data_o;
  logic               busy_o;
  logic               overflow_o;

  int checks = 0;
  int passes = 0;

  dot_acc_unit dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .len_i       (len_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .prod_i      (prod),
    .corr_i      (corr),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .busy_o      (busy_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Modes: 0/2 all ones, 1 all -1 with corr 5, 3 random, 4 near-max products with a large negative correction
  task automatic set_beat(input int mode);
    for (int i = 0; i < 12; i++)
      prod[i] = (mode == 1) ? -18'sd1 : (mode == 3) ? 18'($urandom) : (mode == 4) ? 18'sd131071 : 18'sd1;
    corr = (mode == 1) ? 32'sd5 : (mode == 3) ? 32'($urandom) : (mode == 4) ? -32'sd1000000000 : 32'sd0;
  endtask

  function automatic int beat_of();
    longint s = 0;
    for (int i = 0; i < 12; i++) s += longint'(prod[i]);
    s -= longint'(corr);
    return int'(s);
  endfunction

  task automatic job(input int len, input int mode, input int gap, input int hold);
    int     acc = 0;
    logic   ovf = 1'b0;
    longint nv;
    chk("idle_rdy", 32'(in_ready_o), 0);
    start_i = 1'b1;
    len_i   = 8'(len);
    tick;
    start_i = 1'b0;
    chk("ovf_clr", 32'(overflow_o), 0);
    for (int b = 0; b < len; b++) begin
      repeat (gap) begin
        chk("gap_busy", 32'(busy_o), 1);
        tick;
      end
      set_beat(mode);
      in_valid_i = 1'b1;
      nv = longint'(acc) + longint'(beat_of());
      if (nv != longint'(int'(nv))) ovf = 1'b1;
      acc = int'(nv);
      chk("acc_rdy", 32'(in_ready_o), 1);
      tick;
      in_valid_i = 1'b0;
    end
    if (len > 0) begin
      chk("drain_valid", 32'(out_valid_o), 0);
      chk("drain_rdy", 32'(in_ready_o), 0);
      tick;
    end
    chk("out_valid", 32'(out_valid_o), 1);
    chk("out_data", out_data_o, 32'(acc));
    chk("out_ovf", 32'(overflow_o), 32'(ovf));
    chk("out_rdy", 32'(in_ready_o), 0);
    repeat (hold) begin
      start_i = 1'b1;
      len_i   = 8'($urandom_range(0, 9));
      tick;
      chk("hold_valid", 32'(out_valid_o), 1);
      chk("hold_data", out_data_o, 32'(acc));
    end
    out_ready_i = 1'b1;
    start_i     = 1'b1;
    tick;
    out_ready_i = 1'b0;
    start_i     = 1'b0;
    chk("hs_valid", 32'(out_valid_o), 0);
    chk("hs_busy", 32'(busy_o), 0);
    tick;
    chk("hs_idle", 32'(busy_o), 0);
  endtask

  initial begin
    set_beat(0);
    #3;
    chk("rst_rdy", 32'(in_ready_o), 0);
    chk("rst_valid", 32'(out_valid_o), 0);
    chk("rst_data", out_data_o, 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_ovf", 32'(overflow_o), 0);
    tick;
    tick;
    rst_i = 1'b0;
    tick;
    job(3, 0, 0, 0);
    job(2, 1, 0, 0);
    job(4, 2, 2, 5);
    job(3, 4, 0, 0);
    job(0, 0, 0, 1);
    repeat (4) job($urandom_range(1, 6), 3, $urandom_range(0, 2), $urandom_range(0, 3));
    start_i = 1'b1;
    len_i   = 8'd5;
    tick;
    start_i = 1'b0;
    repeat (2) begin
      set_beat(0);
      in_valid_i = 1'b1;
      tick;
    end
    in_valid_i = 1'b0;
    tick;
    chk("mid_data", out_data_o, 32'd24);
    #2 rst_i = 1'b1;
    #1;
    chk("mid_rst_rdy", 32'(in_ready_o), 0);
    chk("mid_rst_busy", 32'(busy_o), 0);
    chk("mid_rst_data", out_data_o, 0);
    chk("mid_rst_valid", 32'(out_valid_o), 0);
    tick;
    rst_i = 1'b0;
    repeat (3) begin
      tick;
      chk("post_rst_valid", 32'(out_valid_o), 0);
    end
    job(1, 3, 0, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
